// File: rtl/bram_sweep.sv
// bram_sweep: autonomous fill/verify engine for one block RAM.
module bram_sweep #(
  parameter int MEM_SELECT_BITS = 5,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 mode,
  input  logic                       pat_inc,
  input  logic [MEM_SELECT_BITS-1:0] blk,
  input  logic [DATA_BITS-1:0]       seed,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_BITS:0]         err_count,
  output logic [ADDR_BITS-1:0]       first_err_addr,
  output logic [MEM_SELECT_BITS-1:0] mem_select,
  output logic [ADDR_BITS-1:0]       mem_addr,
  output logic [DATA_BITS-1:0]       mem_in,
  output logic                       wr_en,
  output logic                       rd_en,
  input  logic [DATA_BITS-1:0]       mem_out
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state, nxt_state;
  logic [ADDR_BITS-1:0] cnt, nxt_cnt, addr_d, nxt_first;
  logic [DATA_BITS-1:0] seed_r, nxt_seed, exp_d, exp_pat, pat;
  logic [MEM_SELECT_BITS-1:0] blk_r, nxt_blk;
  logic [1:0] mode_r, nxt_mode;
  logic [ADDR_BITS:0] nxt_err;
  logic inc_r, nxt_inc, cmp_v, acc, last, miss, nxt_busy, active;
  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    acc = state == IDLE && start;
    last = &cnt;
    active = state == WRITE || state == READ || state == DRAIN;
    nxt_seed = acc ? seed : seed_r;
    nxt_inc = acc ? pat_inc : inc_r;
    nxt_mode = acc ? mode : mode_r;
    nxt_blk = acc ? blk : blk_r;
    nxt_state = state;
    nxt_cnt = cnt;
    case (state)
      IDLE: if (acc) begin
        nxt_state = (mode == 2'b00 || mode == 2'b10) ? WRITE : READ;
        nxt_cnt = '0;
      end
      WRITE: begin
        nxt_cnt = cnt + 1'b1;
        if (last) nxt_state = mode_r == 2'b10 ? READ : DONE;
      end
      READ: begin
        nxt_cnt = cnt + 1'b1;
        if (last) nxt_state = DRAIN;
      end
      DRAIN: nxt_state = DONE;
      default: nxt_state = IDLE;
    endcase
    if (abort && active) begin
      nxt_state = IDLE;
      nxt_cnt = '0;
    end
    pat = nxt_inc ? nxt_seed + DATA_BITS'(nxt_cnt) : nxt_seed;
    exp_pat = inc_r ? seed_r + DATA_BITS'(cnt) : seed_r;
    miss = cmp_v && (state == READ || state == DRAIN) && mem_out != exp_d;
    nxt_err = acc ? '0 : err_count + {{ADDR_BITS{1'b0}}, miss};
    nxt_first = acc ? '0 : (miss && err_count == '0) ? addr_d : first_err_addr;
    nxt_busy = nxt_state == WRITE || nxt_state == READ || nxt_state == DRAIN;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      seed_r <= '0;
      inc_r <= 1'b0;
      mode_r <= '0;
      blk_r <= '0;
      cmp_v <= 1'b0;
      exp_d <= '0;
      addr_d <= '0;
      err_count <= '0;
      first_err_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      mem_select <= '0;
      mem_addr <= '0;
      mem_in <= '0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      seed_r <= nxt_seed;
      inc_r <= nxt_inc;
      mode_r <= nxt_mode;
      blk_r <= nxt_blk;
      cmp_v <= state == READ;
      exp_d <= exp_pat;
      addr_d <= cnt;
      err_count <= nxt_err;
      first_err_addr <= nxt_first;
      busy <= nxt_busy;
      done <= nxt_state == DONE;
      mem_select <= nxt_busy ? nxt_blk : '0;
      mem_addr <= (nxt_state == WRITE || nxt_state == READ) ? nxt_cnt : '0;
      mem_in <= nxt_state == WRITE ? pat : '0;
      wr_en <= nxt_state == WRITE;
      rd_en <= nxt_state == READ;
    end
  end
endmodule

// File: tb/tb_bram_sweep.sv
// tb_bram_sweep: directed bench for bram_sweep with a behavioural BRAM model.
module tb_bram_sweep;
  logic clk = 0, resetn = 0, start = 0, abort = 0, pat_inc = 0;
  logic [1:0] mode = 0;
  logic [4:0] blk = 0;
  logic [15:0] seed = 0;
  logic busy, done, wr_en, rd_en;
  logic [8:0] err_count;
  logic [7:0] first_err_addr, mem_addr;
  logic [4:0] mem_select;
  logic [15:0] mem_in, mem_out;
  logic [15:0] mem [32][256];
  int n_chk = 0, n_fail = 0;
  int dc, wrn, rdn, bsn, seln;

  bram_sweep dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .mode(mode),
    .pat_inc(pat_inc), .blk(blk), .seed(seed), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr), .mem_select(mem_select),
    .mem_addr(mem_addr), .mem_in(mem_in), .wr_en(wr_en), .rd_en(rd_en), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) mem[mem_select][mem_addr] <= mem_in;
    if (rd_en) mem_out <= mem[mem_select][mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a sweep and runs until done or limit cycles; cycle 1 is the one after the start edge.
  task automatic run(input logic [1:0] m, input logic inc, input logic [4:0] b,
                     input logic [15:0] s, input int limit, input int abort_at, input int rs_at);
    @(negedge clk);
    mode = m; pat_inc = inc; blk = b; seed = s; start = 1;
    @(negedge clk);
    dc = 0; wrn = 0; rdn = 0; bsn = 0; seln = 0;
    for (int c = 1; c <= limit; c++) begin
      wrn += int'(wr_en); rdn += int'(rd_en); bsn += int'(busy);
      if (busy && mem_select != b) seln++;
      if (done) begin dc = c; break; end
      abort = c == abort_at;
      start = c == rs_at;
      if (c == rs_at) begin mode = 2'b00; seed = 16'h1111; end
      @(negedge clk);
    end
    start = 0; abort = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) for (int j = 0; j < 256; j++) mem[i][j] = 16'h0;
    #1;
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_err", err_count, 0); check("rst_first", first_err_addr, 0);
    check("rst_wr", wr_en, 0); check("rst_rd", rd_en, 0);
    check("rst_sel", mem_select, 0); check("rst_addr", mem_addr, 0); check("rst_in", mem_in, 0);
    @(negedge clk); resetn = 1;

    run(2'b00, 1'b0, 5'd1, 16'h5555, 100, 0, 0);
    check("mid_wr_before", wr_en, 1);
    check("mid_addr_before", mem_addr, 100);
    #2 resetn = 0; #1;
    check("mid_rst_wr", wr_en, 0); check("mid_rst_rd", rd_en, 0);
    check("mid_rst_busy", busy, 0); check("mid_rst_err", err_count, 0);
    @(negedge clk); resetn = 1;

    run(2'b10, 1'b1, 5'd3, 16'hA500, 700, 0, 0);
    check("fv_done_cyc", dc, 514); check("fv_wrn", wrn, 256); check("fv_rdn", rdn, 256);
    check("fv_busyn", bsn, 513); check("fv_sel", seln, 0);
    check("fv_err", err_count, 0); check("fv_first", first_err_addr, 0);
    check("fv_w0", mem[3][0], 16'hA500); check("fv_w255", mem[3][255], 16'hA5FF);

    run(2'b00, 1'b0, 5'd2, 16'h1234, 700, 0, 0);
    check("fill_done_cyc", dc, 257); check("fill_wrn", wrn, 256); check("fill_busyn", bsn, 256);
    check("fill_w77", mem[2][77], 16'h1234);
    start = 1; mode = 2'b00; blk = 5'd7; seed = 16'h9999;
    @(negedge clk); start = 0;
    check("b2b_ignored", busy, 0);
    check("b2b_wr", wr_en, 0);
    mem[2][7] = 16'h0000; mem[2][200] = 16'hFFFF;
    run(2'b01, 1'b0, 5'd2, 16'h1234, 700, 0, 0);
    check("ver_done_cyc", dc, 258); check("ver_rdn", rdn, 256); check("ver_wrn", wrn, 0);
    check("ver_err", err_count, 2); check("ver_first", first_err_addr, 7);
    check("ver_hold", err_count, 2);

    run(2'b11, 1'b0, 5'd5, 16'hFFFF, 700, 0, 0);
    check("all_done_cyc", dc, 258); check("all_err", err_count, 9'h100); check("all_first", first_err_addr, 0);

    run(2'b01, 1'b0, 5'd5, 16'hFFFF, 80, 50, 20);
    check("abort_no_done", dc, 0); check("abort_busyn", bsn, 50); check("abort_rdn", rdn, 50);
    check("abort_wrn", wrn, 0); check("abort_err", err_count, 49); check("abort_first", first_err_addr, 0);
    check("abort_nowrite", mem[5][0], 16'h0);

    run(2'b00, 1'b1, 5'd6, 16'hFFF0, 700, 0, 0);
    check("wrap_done_cyc", dc, 257);
    check("wrap_w0", mem[6][0], 16'hFFF0); check("wrap_w16", mem[6][16], 16'h0000);
    check("wrap_w255", mem[6][255], 16'h00EF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_sweep.md
# bram_sweep

Autonomous fill/verify engine for one embedded block RAM. It sits between the UART command controller and the BRAM array, and drives the same select/address/data/enable bus the controller uses. Once started, it writes a deterministic pattern to all 256 words of one selected block, reads them back, or does both. It reports the mismatch count and the first failing address, so the host can check a block with one command instead of 512 UART transactions.

## Interface
Parameters:
- MEM_SELECT_BITS, 5: width of block select; must equal $clog2 of the block count.
- ADDR_BITS, 8: word address width inside one block.
- DATA_BITS, 16: word width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; ignored while busy.
- abort  in  1  stops an active sweep; no done pulse.
- mode  in  2  00 fill, 01 verify, 10 fill-then-verify, 11 reserved (treated as 01).
- pat_inc  in  1  0: every word = seed; 1: word = seed + addr (mod 2^DATA_BITS).
- blk  in  MEM_SELECT_BITS  target block.
- seed  in  DATA_BITS  pattern seed.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a sweep completes.
- err_count  out  ADDR_BITS+1  number of mismatches in the last verify pass (0..256).
- first_err_addr  out  ADDR_BITS  address of the first mismatch; 0 if there is none.
- mem_select  out  MEM_SELECT_BITS  BRAM block select.
- mem_addr  out  ADDR_BITS  BRAM word address.
- mem_in  out  DATA_BITS  BRAM write data.
- wr_en  out  1  BRAM write enable.
- rd_en  out  1  BRAM read enable.
- mem_out  in  DATA_BITS  BRAM read data, valid one cycle after rd_en.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on start, latch mode, pat_inc, blk and seed.
  - Clear err_count and first_err_addr.
  - Go to WRITE if mode=00 or 10, otherwise go to READ.
- WRITE: wr_en=1 with mem_addr = addr counter and mem_in = pattern(addr). The counter runs 0..255.
  - At 255: go to READ if mode=10, otherwise go to DONE.
- READ: rd_en=1 with mem_addr = addr counter, 0..255.
  - The expected word and address are delayed one cycle to match the BRAM read latency.
  - At 255: go to DRAIN.
- Compare: every cycle after a read cycle (READ cycles after the first, plus DRAIN), compare mem_out to the delayed expected word.
  - On a mismatch, increment err_count.
  - If err_count was 0, capture the delayed address into first_err_addr.
- DRAIN: perform the last compare, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- mem_select = latched blk whenever busy; otherwise 0.
- Enables and address are 0 in IDLE, DRAIN and DONE.
- abort in WRITE, READ or DRAIN: go to IDLE next cycle.
  - Enables drop in that cycle's registered outputs.
  - err_count and first_err_addr keep their partial values.
  - No done pulse.
- Arithmetic: the pattern add truncates to DATA_BITS. The address counter is ADDR_BITS wide, and the terminal count is detected at all-ones, not by wrap.
- The result registers hold until the next accepted start.
- start and abort together in IDLE: start wins. While busy, start is ignored.

## Timing
- All outputs are registered.
- Reset values: busy 0, done 0, err_count 0, first_err_addr 0, mem_select 0, mem_addr 0, mem_in 0, wr_en 0, rd_en 0, state IDLE.
- Cycle numbering: start is sampled high at edge 0.
- Fill (00):
  - wr_en high in cycles 1..256 for addresses 0..255.
  - done in cycle 257.
  - busy high in cycles 1..256.
- Verify (01):
  - rd_en high in cycles 1..256.
  - Compares in cycles 2..257.
  - done in cycle 258.
- Fill-then-verify (10):
  - Writes in cycles 1..256.
  - Reads in cycles 257..512.
  - DRAIN in cycle 513.
  - done in cycle 514.
- Back-to-back: a start in the done cycle is ignored. The earliest accepted start is the cycle after done.
- resetn low at any time:
  - All outputs are cleared asynchronously, and the state goes to IDLE.
  - The BRAM contents are left as they are.

## Test plan
- Reset mid-WRITE at cycle 100 -> wr_en, rd_en, busy and err_count are 0 immediately. The next start runs normally.
- mode=10, blk=3, seed=0xA500, pat_inc=1, behavioural BRAM model -> word 255 = 0xA5FF. done at cycle 514, err_count=0, first_err_addr=0.
- Fill blk=2 with seed 0x1234 constant, corrupt words 7 and 200 in the model, then verify -> err_count=2, first_err_addr=7.
- Verify a block holding all zeros against seed 0xFFFF, pat_inc=0 -> err_count=256 (9'h100), first_err_addr=0.
- abort at cycle 50 of a verify -> no done pulse, busy low next cycle, partial err_count retained. A start pulsed during busy is ignored.
- seed=0xFFF0, pat_inc=1 fill -> addr 16 holds 0x0000 (wrap), addr 255 holds 0x00EF.
